idex_hazard_reg: RTL and testbench
==================================

# idex_hazard_reg

ID/EX pipeline register with integrated load-use hazard control for the RNS RISC pipeline. Captures forwarded ID-stage operands, addresses and control, and presents them to EX and the forwarding unit as the `*_IDtoEX` / `*_EX` signals. Detects a load in EX whose destination feeds the instruction in ID. On detection it stalls IF/ID and injects bubbles for a programmable number of cycles. It also honours pipeline flush and EX multicycle hold.

## Interface
- `NUM_DOMAINS`, 1: residue domains; operand width is NUM_DOMAINS*8
- `LOAD_STALL_CYCLES`, 1: bubbles inserted per load-use hazard (1..15)
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `op1_addr_ID`, `op2_addr_ID`  in  4 each  source register addresses in ID
- `op3_addr_ID`  in  3  third source address, zero-extended to 4 bits for compares
- `op1_data_ID`, `op2_data_ID`, `op3_data_ID`  in  NUM_DOMAINS*8 each  forwarded ID operands
- `dest_addr_ID`  in  4  destination register
- `reg_wr_en_ID`, `load_true_ID`  in  1 each  write-enable and load flag
- `ctrl_ID`  in  8  opaque EX control bundle
- `valid_ID`  in  1  ID holds a real instruction
- `flush`  in  1  squash ID/EX contents (taken branch)
- `ex_hold`  in  1  EX busy; freeze ID/EX
- `op1_addr_IDtoEX`, `op2_addr_IDtoEX`  out  4 each  registered addresses
- `op3_addr_IDtoEX`  out  3  registered address
- `op1_data_IDtoEX`, `op2_data_IDtoEX`, `op3_data_IDtoEX`  out  NUM_DOMAINS*8 each  registered operands
- `dest_addr_EX`  out  4  registered destination
- `reg_wr_en_EX`, `load_true_EX`, `valid_EX`  out  1 each  registered flags
- `ctrl_EX`  out  8  registered control
- `stall_IFID`  out  1  hold PC and IF/ID this cycle (combinational)
- `hazard_cnt`  out  16  saturating count of load-use hazard events

## Operation
- Hazard: `valid_EX & load_true_EX & reg_wr_en_EX & valid_ID`, AND `dest_addr_EX` equals op1_addr_ID, op2_addr_ID or {1'b0,op3_addr_ID}.
- FSM states: RUN, STALL. A 4-bit down-counter `cnt` is used in STALL.
- Per-cycle priority: flush > ex_hold > stall/hazard > normal load.
- **flush:**
  - Next EX is a bubble; state goes to RUN; cnt cleared.
  - stall_IFID=0, unless ex_hold is also asserted.
  - Flush during STALL aborts the stall.
- **ex_hold (no flush):**
  - All EX registers, state and cnt hold.
  - stall_IFID=1.
  - hazard_cnt does not increment.
- **RUN with hazard:**
  - stall_IFID=1; next EX is a bubble; hazard_cnt++ (saturates at 0xFFFF).
  - If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-1 and state goes to STALL; otherwise remain in RUN.
- **STALL:**
  - stall_IFID=1; next EX is a bubble; cnt--.
  - When cnt==1, next state is RUN.
- **RUN without hazard:** all ID inputs are captured. valid_EX <= valid_ID. When valid_ID=0, reg_wr_en_EX and load_true_EX are forced to 0.
- **Bubble:**
  - valid_EX, reg_wr_en_EX, load_true_EX and ctrl_EX go to 0.
  - Address and data fields go to 0.
- Total stall per hazard = LOAD_STALL_CYCLES cycles. The stalled instruction is captured on the first RUN cycle after the stall.

## Timing
- Latency: ID inputs to `*_IDtoEX`/`*_EX` is 1 cycle.
- stall_IFID is combinational from the current state and inputs, with no register delay.
- Reset (asynchronous, any time including mid-stall):
  - All outputs 0; state RUN; cnt 0; hazard_cnt 0.
  - stall_IFID=0, because its inputs are 0.
- Simultaneous hazard and ex_hold: hold wins. The hazard is re-evaluated on the first non-hold cycle and counted once.
- Back-to-back hazards: a second load-use after a stall ends is counted and stalled independently.

## Structure
- Shared package `rns_pipe_pkg`:
  - state enum {RUN, STALL}
  - CTRL_W=8
  - bubble constants (zero control bundle)
- Sub-module `load_use_detect`: purely combinational 3-way address compare producing `hazard`. It is reusable by any future MEM-stage detector.
- The top module holds the FSM, counter, pipeline register and perf counter.

## Test plan
- **Normal flow.** Stimulus: LW-free ADD, op1_addr_ID=3, data 0x5A, valid_ID=1. Required: next cycle op1_data_IDtoEX=0x5A, valid_EX=1, stall_IFID=0.
- **Single-cycle load-use.** Stimulus: LW r4 in EX, ID reads op2_addr_ID=4. Required: stall_IFID=1 for one cycle; next valid_EX=0; hazard_cnt=1; instruction captured the following cycle.
- **op3 compare with LOAD_STALL_CYCLES=3.** Stimulus: load to r5, op3_addr_ID=5. Required: stall_IFID high for exactly 3 cycles; 3 bubbles.
- **Flush mid-STALL.** Stimulus: flush asserted on the 2nd stall cycle. Required: stall_IFID=0 that cycle; state RUN; valid_EX=0.
- **ex_hold with simultaneous hazard.** Stimulus: ex_hold for 2 cycles. Required: EX outputs frozen; stall_IFID=1; hazard_cnt unchanged until hold drops, then +1.
- **Asynchronous reset mid-stall, then counter saturation.** Stimulus: rst_n low mid-stall; later, force 65536 hazards. Required: after reset all outputs 0 immediately; after the hazards, hazard_cnt=0xFFFF.

Source files
------------

// File: rtl/idex_hazard_reg_pkg.sv
// rns_pipe_pkg: shared pipeline types and the bubble constant for the RNS RISC pipeline.
package rns_pipe_pkg;
    localparam int CTRL_W = 8;
    typedef enum logic {RUN, STALL} state_t;
    typedef struct packed {
        logic              valid;
        logic              reg_wr_en;
        logic              load_true;
        logic [CTRL_W-1:0] ctrl;
        logic [3:0]        dest;
        logic [3:0]        op1_addr;
        logic [3:0]        op2_addr;
        logic [2:0]        op3_addr;
    } ex_ctrl_t;
    localparam ex_ctrl_t BUBBLE_CTRL = '0;
endpackage

// File: rtl/idex_hazard_reg_if.sv
// idex_hazard_reg_if: ID-side inputs and EX-side outputs of the ID/EX register.
interface idex_hazard_reg_if #(parameter int NUM_DOMAINS = 1);
    localparam int W = NUM_DOMAINS * 8;
    logic [3:0]   op1_addr_ID, op2_addr_ID, dest_addr_ID;
    logic [2:0]   op3_addr_ID;
    logic [W-1:0] op1_data_ID, op2_data_ID, op3_data_ID;
    logic         reg_wr_en_ID, load_true_ID, valid_ID, flush, ex_hold;
    logic [7:0]   ctrl_ID;
    logic [3:0]   op1_addr_IDtoEX, op2_addr_IDtoEX, dest_addr_EX;
    logic [2:0]   op3_addr_IDtoEX;
    logic [W-1:0] op1_data_IDtoEX, op2_data_IDtoEX, op3_data_IDtoEX;
    logic         reg_wr_en_EX, load_true_EX, valid_EX, stall_IFID;
    logic [7:0]   ctrl_EX;
    logic [15:0]  hazard_cnt;
    modport master (
        output op1_addr_ID, op2_addr_ID, op3_addr_ID, dest_addr_ID,
        output op1_data_ID, op2_data_ID, op3_data_ID,
        output reg_wr_en_ID, load_true_ID, valid_ID, ctrl_ID, flush, ex_hold,
        input  op1_addr_IDtoEX, op2_addr_IDtoEX, op3_addr_IDtoEX, dest_addr_EX,
        input  op1_data_IDtoEX, op2_data_IDtoEX, op3_data_IDtoEX,
        input  reg_wr_en_EX, load_true_EX, valid_EX, ctrl_EX, stall_IFID, hazard_cnt
    );
    modport slave (
        input  op1_addr_ID, op2_addr_ID, op3_addr_ID, dest_addr_ID,
        input  op1_data_ID, op2_data_ID, op3_data_ID,
        input  reg_wr_en_ID, load_true_ID, valid_ID, ctrl_ID, flush, ex_hold,
        output op1_addr_IDtoEX, op2_addr_IDtoEX, op3_addr_IDtoEX, dest_addr_EX,
        output op1_data_IDtoEX, op2_data_IDtoEX, op3_data_IDtoEX,
        output reg_wr_en_EX, load_true_EX, valid_EX, ctrl_EX, stall_IFID, hazard_cnt
    );
endinterface

// File: rtl/idex_hazard_reg_load_use_detect.sv
// load_use_detect: flags a valid load in EX whose destination is read by the valid instruction in ID.
module load_use_detect (
    input  logic       valid_ex,
    input  logic       load_ex,
    input  logic       wr_en_ex,
    input  logic [3:0] dest_ex,
    input  logic       valid_id,
    input  logic [3:0] op1_addr,
    input  logic [3:0] op2_addr,
    input  logic [2:0] op3_addr,
    output logic       hazard
);
    logic match;
    assign match  = (dest_ex == op1_addr) | (dest_ex == op2_addr) | (dest_ex == {1'b0, op3_addr});
    assign hazard = valid_ex & load_ex & wr_en_ex & valid_id & match;
endmodule

// File: rtl/idex_hazard_reg.sv
// idex_hazard_reg: ID/EX pipeline register with load-use stall FSM, flush/hold control and hazard counter.
module idex_hazard_reg
    import rns_pipe_pkg::*;
#(
    parameter int NUM_DOMAINS       = 1,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input logic             clk,
    input logic             rst_n,
    idex_hazard_reg_if.slave bus
);
    localparam int         W        = NUM_DOMAINS * 8;
    localparam logic [3:0] CNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  hazard_cnt_q;
    ex_ctrl_t     ex_q, ex_d;
    logic [W-1:0] d1_q, d2_q, d3_q;
    logic         hazard, bubble, count, load;

    load_use_detect u_detect (
        .valid_ex (ex_q.valid),
        .load_ex  (ex_q.load_true),
        .wr_en_ex (ex_q.reg_wr_en),
        .dest_ex  (ex_q.dest),
        .valid_id (bus.valid_ID),
        .op1_addr (bus.op1_addr_ID),
        .op2_addr (bus.op2_addr_ID),
        .op3_addr (bus.op3_addr_ID),
        .hazard   (hazard)
    );

    // flush beats hold, hold beats stall/hazard; hold freezes everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        count   = 1'b0;
        if (bus.flush) begin
            state_d = RUN;
            cnt_d   = '0;
            bubble  = 1'b1;
        end else if (!bus.ex_hold) begin
            if (state_q == STALL) begin
                bubble  = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? RUN : STALL;
            end else if (hazard) begin
                bubble = 1'b1;
                count  = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = STALL;
                    cnt_d   = CNT_INIT;
                end
            end
        end
        ex_d = BUBBLE_CTRL;
        if (!bubble) begin
            ex_d.valid     = bus.valid_ID;
            ex_d.reg_wr_en = bus.reg_wr_en_ID & bus.valid_ID;
            ex_d.load_true = bus.load_true_ID & bus.valid_ID;
            ex_d.ctrl      = bus.ctrl_ID;
            ex_d.dest      = bus.dest_addr_ID;
            ex_d.op1_addr  = bus.op1_addr_ID;
            ex_d.op2_addr  = bus.op2_addr_ID;
            ex_d.op3_addr  = bus.op3_addr_ID;
        end
    end

    assign load           = bus.flush | ~bus.ex_hold;
    assign bus.stall_IFID = bus.ex_hold | (~bus.flush & ((state_q == STALL) | hazard));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            hazard_cnt_q <= '0;
            ex_q         <= BUBBLE_CTRL;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (count && hazard_cnt_q != 16'hFFFF)
                hazard_cnt_q <= hazard_cnt_q + 16'd1;
            if (load) begin
                ex_q <= ex_d;
                d1_q <= bubble ? '0 : bus.op1_data_ID;
                d2_q <= bubble ? '0 : bus.op2_data_ID;
                d3_q <= bubble ? '0 : bus.op3_data_ID;
            end
        end
    end

    assign bus.op1_addr_IDtoEX = ex_q.op1_addr;
    assign bus.op2_addr_IDtoEX = ex_q.op2_addr;
    assign bus.op3_addr_IDtoEX = ex_q.op3_addr;
    assign bus.dest_addr_EX    = ex_q.dest;
    assign bus.reg_wr_en_EX    = ex_q.reg_wr_en;
    assign bus.load_true_EX    = ex_q.load_true;
    assign bus.valid_EX        = ex_q.valid;
    assign bus.ctrl_EX         = ex_q.ctrl;
    assign bus.op1_data_IDtoEX = d1_q;
    assign bus.op2_data_IDtoEX = d2_q;
    assign bus.op3_data_IDtoEX = d3_q;
    assign bus.hazard_cnt      = hazard_cnt_q;
endmodule

// File: tb/tb_idex_hazard_reg.sv
// tb_idex_hazard_reg: directed checks of idex_hazard_reg with one-cycle (d1) and three-cycle (d3) stall builds.
module tb_idex_hazard_reg;
    logic       clk = 1'b0, rst_n = 1'b1;
    logic [3:0] a1, a2, dst;
    logic [2:0] a3;
    logic [7:0] x1, x2, x3, ctl;
    logic       wr, ld, vld, fl, hold;
    int         n_cmp = 0, n_err = 0, exp1 = 0, exp3 = 0;

    always #5 clk = ~clk;

    idex_hazard_reg_if #(.NUM_DOMAINS(1)) b1 ();
    idex_hazard_reg_if #(.NUM_DOMAINS(1)) b3 ();

    idex_hazard_reg #(.NUM_DOMAINS(1), .LOAD_STALL_CYCLES(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    idex_hazard_reg #(.NUM_DOMAINS(1), .LOAD_STALL_CYCLES(3)) d3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    assign b1.op1_addr_ID = a1;   assign b3.op1_addr_ID = a1;
    assign b1.op2_addr_ID = a2;   assign b3.op2_addr_ID = a2;
    assign b1.op3_addr_ID = a3;   assign b3.op3_addr_ID = a3;
    assign b1.dest_addr_ID = dst; assign b3.dest_addr_ID = dst;
    assign b1.op1_data_ID = x1;   assign b3.op1_data_ID = x1;
    assign b1.op2_data_ID = x2;   assign b3.op2_data_ID = x2;
    assign b1.op3_data_ID = x3;   assign b3.op3_data_ID = x3;
    assign b1.ctrl_ID = ctl;      assign b3.ctrl_ID = ctl;
    assign b1.reg_wr_en_ID = wr;  assign b3.reg_wr_en_ID = wr;
    assign b1.load_true_ID = ld;  assign b3.load_true_ID = ld;
    assign b1.valid_ID = vld;     assign b3.valid_ID = vld;
    assign b1.flush = fl;         assign b3.flush = fl;
    assign b1.ex_hold = hold;     assign b3.ex_hold = hold;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] o1, input logic [3:0] o2, input logic [2:0] o3, input logic [3:0] d,
                          input logic w, input logic l, input logic [7:0] c, input logic [7:0] v1, input logic [7:0] v2, input logic [7:0] v3);
        a1 = o1; a2 = o2; a3 = o3; dst = d; wr = w; ld = l; ctl = c; x1 = v1; x2 = v2; x3 = v3; vld = 1'b1;
    endtask

    task automatic idle();
        set_id(4'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        vld = 1'b0; fl = 1'b0; hold = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (b1.valid_EX !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", b1.valid_EX); end
        n_cmp++; if (b1.op1_data_IDtoEX !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", b1.op1_data_IDtoEX); end
        n_cmp++; if (b1.dest_addr_EX !== 4'h0) begin n_err++; $display("FAIL rst_dest: got %h want 0", b1.dest_addr_EX); end
        n_cmp++; if (b1.ctrl_EX !== 8'h00) begin n_err++; $display("FAIL rst_ctrl: got %h want 00", b1.ctrl_EX); end
        n_cmp++; if (b1.hazard_cnt !== 16'h0) begin n_err++; $display("FAIL rst_hcnt: got %h want 0000", b1.hazard_cnt); end
        n_cmp++; if (b1.stall_IFID !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", b1.stall_IFID); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        set_id(4'd3, 4'd1, 3'd0, 4'd2, 1'b1, 1'b0, 8'h11, 8'h5A, 8'h00, 8'h00);
        #1;
        n_cmp++; if (b1.stall_IFID !== 1'b0) begin n_err++; $display("FAIL norm_stall: got %b want 0", b1.stall_IFID); end
        tick();
        n_cmp++; if (b1.op1_data_IDtoEX !== 8'h5A) begin n_err++; $display("FAIL norm_data: got %h want 5a", b1.op1_data_IDtoEX); end
        n_cmp++; if (b1.valid_EX !== 1'b1) begin n_err++; $display("FAIL norm_valid: got %b want 1", b1.valid_EX); end
        n_cmp++; if (b1.op1_addr_IDtoEX !== 4'd3) begin n_err++; $display("FAIL norm_addr: got %h want 3", b1.op1_addr_IDtoEX); end
        n_cmp++; if (b1.ctrl_EX !== 8'h11) begin n_err++; $display("FAIL norm_ctrl: got %h want 11", b1.ctrl_EX); end
        n_cmp++; if (b1.reg_wr_en_EX !== 1'b1) begin n_err++; $display("FAIL norm_wr: got %b want 1", b1.reg_wr_en_EX); end
    endtask

    task automatic test_invalid_id();
        set_id(4'd1, 4'd1, 3'd0, 4'd6, 1'b1, 1'b1, 8'h22, 8'h01, 8'h00, 8'h00);
        vld = 1'b0;
        tick();
        n_cmp++; if (b1.reg_wr_en_EX !== 1'b0 || b1.load_true_EX !== 1'b0) begin n_err++; $display("FAIL inv_flags: got wr=%b ld=%b want 0 0", b1.reg_wr_en_EX, b1.load_true_EX); end
        n_cmp++; if (b1.ctrl_EX !== 8'h22) begin n_err++; $display("FAIL inv_ctrl: got %h want 22", b1.ctrl_EX); end
    endtask

    task automatic test_load_use();
        set_id(4'd0, 4'd0, 3'd0, 4'd4, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd6, 4'd4, 3'd0, 4'd7, 1'b1, 1'b0, 8'h05, 8'h00, 8'h33, 8'h00);
        #1;
        n_cmp++; if (b1.stall_IFID !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %b want 1", b1.stall_IFID); end
        tick(); exp1++; exp3++;
        n_cmp++; if (b1.valid_EX !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got %b want 0", b1.valid_EX); end
        n_cmp++; if (b1.hazard_cnt !== 16'(exp1)) begin n_err++; $display("FAIL lu_hcnt: got %0d want %0d", b1.hazard_cnt, exp1); end
        n_cmp++; if (b1.stall_IFID !== 1'b0) begin n_err++; $display("FAIL lu_unstall: got %b want 0", b1.stall_IFID); end
        tick();
        n_cmp++; if (b1.valid_EX !== 1'b1 || b1.op2_data_IDtoEX !== 8'h33 || b1.dest_addr_EX !== 4'd7) begin n_err++; $display("FAIL lu_capture: got v=%b d=%h dst=%h want 1 33 7", b1.valid_EX, b1.op2_data_IDtoEX, b1.dest_addr_EX); end
    endtask

    task automatic test_op3_stall3();
        set_id(4'd0, 4'd0, 3'd0, 4'd5, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd1, 4'd2, 3'd5, 4'd6, 1'b1, 1'b0, 8'h07, 8'h00, 8'h00, 8'h77);
        exp1++; exp3++;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (b3.stall_IFID !== 1'b1) begin n_err++; $display("FAIL s3_stall%0d: got %b want 1", i, b3.stall_IFID); end
            tick();
            n_cmp++; if (b3.valid_EX !== 1'b0) begin n_err++; $display("FAIL s3_bubble%0d: got %b want 0", i, b3.valid_EX); end
        end
        #1;
        n_cmp++; if (b3.stall_IFID !== 1'b0) begin n_err++; $display("FAIL s3_release: got %b want 0", b3.stall_IFID); end
        tick();
        n_cmp++; if (b3.valid_EX !== 1'b1 || b3.op3_data_IDtoEX !== 8'h77 || b3.op3_addr_IDtoEX !== 3'd5) begin n_err++; $display("FAIL s3_capture: got v=%b d=%h a=%h want 1 77 5", b3.valid_EX, b3.op3_data_IDtoEX, b3.op3_addr_IDtoEX); end
        n_cmp++; if (b3.hazard_cnt !== 16'(exp3)) begin n_err++; $display("FAIL s3_hcnt: got %0d want %0d", b3.hazard_cnt, exp3); end
    endtask

    task automatic test_flush_mid_stall();
        set_id(4'd0, 4'd0, 3'd0, 4'd5, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd5, 4'd0, 3'd0, 4'd6, 1'b1, 1'b0, 8'h09, 8'h44, 8'h00, 8'h00);
        tick(); exp1++;
        fl = 1'b1;
        #1;
        n_cmp++; if (b3.stall_IFID !== 1'b0) begin n_err++; $display("FAIL fl_stall: got %b want 0", b3.stall_IFID); end
        tick();
        fl = 1'b0;
        n_cmp++; if (b3.valid_EX !== 1'b0) begin n_err++; $display("FAIL fl_bubble: got %b want 0", b3.valid_EX); end
        #1;
        n_cmp++; if (b3.stall_IFID !== 1'b0) begin n_err++; $display("FAIL fl_run: got %b want 0", b3.stall_IFID); end
        tick();
        n_cmp++; if (b3.valid_EX !== 1'b1 || b3.op1_data_IDtoEX !== 8'h44) begin n_err++; $display("FAIL fl_capture: got v=%b d=%h want 1 44", b3.valid_EX, b3.op1_data_IDtoEX); end
    endtask

    task automatic test_hold_hazard();
        set_id(4'd0, 4'd0, 3'd0, 4'd4, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd4, 4'd0, 3'd0, 4'd8, 1'b1, 1'b0, 8'h01, 8'h99, 8'h00, 8'h00);
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (b1.stall_IFID !== 1'b1) begin n_err++; $display("FAIL hd_stall%0d: got %b want 1", i, b1.stall_IFID); end
            tick();
            n_cmp++; if (b1.valid_EX !== 1'b1 || b1.dest_addr_EX !== 4'd4 || b1.load_true_EX !== 1'b1 || b1.ctrl_EX !== 8'h3C) begin n_err++; $display("FAIL hd_frozen%0d: got v=%b dst=%h ld=%b c=%h want 1 4 1 3c", i, b1.valid_EX, b1.dest_addr_EX, b1.load_true_EX, b1.ctrl_EX); end
            n_cmp++; if (b1.hazard_cnt !== 16'(exp1)) begin n_err++; $display("FAIL hd_hcnt%0d: got %0d want %0d", i, b1.hazard_cnt, exp1); end
        end
        hold = 1'b0;
        #1;
        n_cmp++; if (b1.stall_IFID !== 1'b1) begin n_err++; $display("FAIL hd_hazard: got %b want 1", b1.stall_IFID); end
        tick(); exp1++;
        n_cmp++; if (b1.valid_EX !== 1'b0 || b1.hazard_cnt !== 16'(exp1)) begin n_err++; $display("FAIL hd_count: got v=%b cnt=%0d want 0 %0d", b1.valid_EX, b1.hazard_cnt, exp1); end
        tick();
        n_cmp++; if (b1.op1_data_IDtoEX !== 8'h99) begin n_err++; $display("FAIL hd_capture: got %h want 99", b1.op1_data_IDtoEX); end
    endtask

    task automatic test_back_to_back();
        set_id(4'd0, 4'd0, 3'd0, 4'd2, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd2, 4'd0, 3'd0, 4'd3, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        n_cmp++; if (b1.stall_IFID !== 1'b1) begin n_err++; $display("FAIL bb_stall1: got %b want 1", b1.stall_IFID); end
        tick(); exp1++;
        tick();
        n_cmp++; if (b1.dest_addr_EX !== 4'd3 || b1.load_true_EX !== 1'b1) begin n_err++; $display("FAIL bb_load2: got dst=%h ld=%b want 3 1", b1.dest_addr_EX, b1.load_true_EX); end
        set_id(4'd3, 4'd0, 3'd0, 4'd9, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        n_cmp++; if (b1.stall_IFID !== 1'b1) begin n_err++; $display("FAIL bb_stall2: got %b want 1", b1.stall_IFID); end
        tick(); exp1++;
        n_cmp++; if (b1.hazard_cnt !== 16'(exp1)) begin n_err++; $display("FAIL bb_hcnt: got %0d want %0d", b1.hazard_cnt, exp1); end
    endtask

    task automatic test_reset_mid_stall();
        set_id(4'd0, 4'd0, 3'd0, 4'd5, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_id(4'd0, 4'd0, 3'd5, 4'd6, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h66);
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b3.stall_IFID !== 1'b0 || b3.valid_EX !== 1'b0 || b3.hazard_cnt !== 16'h0) begin n_err++; $display("FAIL rm_zero: got st=%b v=%b cnt=%0d want 0 0 0", b3.stall_IFID, b3.valid_EX, b3.hazard_cnt); end
        n_cmp++; if (b3.dest_addr_EX !== 4'h0 || b3.op1_addr_IDtoEX !== 4'h0 || b3.ctrl_EX !== 8'h00 || b3.load_true_EX !== 1'b0) begin n_err++; $display("FAIL rm_fields: got dst=%h a=%h c=%h ld=%b want 0 0 00 0", b3.dest_addr_EX, b3.op1_addr_IDtoEX, b3.ctrl_EX, b3.load_true_EX); end
        rst_n = 1'b1;
        exp1 = 0;
        tick();
        n_cmp++; if (b3.valid_EX !== 1'b1 || b3.op3_data_IDtoEX !== 8'h66) begin n_err++; $display("FAIL rm_run: got v=%b d=%h want 1 66", b3.valid_EX, b3.op3_data_IDtoEX); end
    endtask

    task automatic test_saturation();
        force d1.hazard_cnt_q = 16'hFFFD;
        #1;
        release d1.hazard_cnt_q;
        set_id(4'd1, 4'd0, 3'd0, 4'd1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) tick();
        n_cmp++; if (b1.hazard_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_step: got %h want fffe", b1.hazard_cnt); end
        repeat (6) tick();
        n_cmp++; if (b1.hazard_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h want ffff", b1.hazard_cnt); end
    endtask

    initial begin
        fl = 1'b0; hold = 1'b0;
        test_reset();
        test_normal();
        test_invalid_id();
        test_load_use();
        idle();
        test_op3_stall3();
        idle();
        test_flush_mid_stall();
        idle();
        test_hold_hazard();
        idle();
        test_back_to_back();
        idle();
        test_reset_mid_stall();
        idle();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
